amo_sequencer: RTL and testbench
================================

# amo_sequencer

Sequencer for RV32A atomics (LR.W, SC.W, AMO*.W) beside the multicycle datapath. It takes one decoded atomic command and runs the read/modify/write memory sequence on a simple valid/ready bus. It owns the LR/SC reservation and returns the rd value or a fault to the main control unit. The control FSM hands it the command and stalls until the response arrives.

## Interface
- `RESV_GRANULE_BITS`, default 2: number of low address bits ignored in reservation compare and snoop match (2 = word granule).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 5: funct5 from the instruction.
- `cmd_addr` in 32: effective address (rs1).
- `cmd_wdata` in 32: rs2 value; ignored for LR.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: value for rd.
- `rsp_fault` out 1: qualifies `rsp_valid`; rd must not be written.
- `rsp_cause` out 2: 0 = none, 1 = misaligned, 2 = illegal op.
- `mem_valid` out 1: memory request.
- `mem_ready` in 1: request completes this cycle.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: store data.
- `mem_wstrb` out 4: 4'b1111 on write, 0 on read.
- `mem_rdata` in 32: sampled when `mem_valid && mem_ready` on a read.
- `snoop_valid` in 1: another master or a plain store wrote memory.
- `snoop_addr` in 32: address of that write.
- `resv_valid` out 1: reservation state, for debug and CSR visibility.

## Operation
- **Opcodes** (funct5):
  - ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100.
  - MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
  - Any other value is illegal.
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE:** on `cmd_valid`, latch op, addr and wdata, then choose a path:
  - Misaligned (`addr[1:0]!=0`) or illegal op → RESP with fault. Misaligned takes precedence over illegal. No memory access.
  - LR → READ.
  - AMO → READ.
  - SC with reservation valid and matching → WRITE.
  - SC otherwise → RESP, `rsp_rdata`=1, no write.
- **READ:** hold the request until `mem_ready`, then capture `old=mem_rdata`.
  - LR: set the reservation on that word → RESP, `rsp_rdata`=old.
  - AMO: → WRITE.
- **WRITE:** data is new = f(old, wdata), held until `mem_ready` → RESP.
  - f: add is mod 2^32; min/max are signed; minu/maxu are unsigned; swap returns wdata.
  - SC: `mem_wdata`=wdata; `rsp_rdata`=0 on success. AMO: `rsp_rdata`=old.
- **RESP:** `rsp_valid`=1 for one cycle → IDLE.
- **Reservation:**
  - Any accepted SC clears it, whether it succeeds or fails.
  - `snoop_valid` with `snoop_addr[31:RESV_GRANULE_BITS]` matching clears it.
  - A new LR overwrites it.
  - It is never cleared by non-matching snoops.
- **Simultaneous events:**
  - A snoop in the same cycle as SC acceptance wins: the SC fails.
  - A snoop in the same cycle as LR's `mem_ready` wins: the reservation ends invalid.
- **Reset:** state IDLE; reservation invalid. `mem_valid`, `rsp_valid`, `rsp_fault`, `mem_wstrb` are 0; `rsp_rdata`, `mem_addr`, `mem_wdata` are 0.
  - Reset mid-operation abandons the sequence.
  - No response is produced for the aborted command.

## Timing
- Command acceptance is cycle 0.
- `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered. They are stable from assertion until the completing cycle.
- After the completing cycle, `mem_valid` drops for at least one cycle.
- Latency with zero-wait memory (`mem_ready` high whenever `mem_valid`):
  - AMO: READ cycle 1, WRITE cycle 3, `rsp_valid` cycle 5.
  - LR: `rsp_valid` cycle 3.
  - Successful SC: `rsp_valid` cycle 3.
  - Failed SC or fault: `rsp_valid` cycle 1.
- Each wait cycle adds one cycle per access.
- `cmd_ready` is low from cycle 1 until the cycle after `rsp_valid`.
- `rsp_rdata`, `rsp_fault` and `rsp_cause` are valid only while `rsp_valid` is high.

## Configuration
- `KIANV_AMO_MINMAX_EN` defined: MIN, MAX, MINU and MAXU are executed, including the signed/unsigned comparator.
- `KIANV_AMO_MINMAX_EN` undefined: these four opcodes are illegal (`rsp_fault`=1, `rsp_cause`=2, no memory access), and the comparator logic is removed.

## Test plan
- AMOADD at 0x100: mem holds 0x7FFFFFFF, wdata=1 → read 0x100, write 0x80000000, `rsp_rdata`=0x7FFFFFFF, `rsp_valid` at cycle 5 with zero-wait memory.
- LR at 0x200 then SC at 0x200 with wdata=0xCAFE → SC writes 0xCAFE with `mem_wstrb`=1111 and returns 0; a second SC returns 1 with no `mem_valid`.
- LR at 0x200, then snoop at 0x202 (same word), then SC → SC returns 1, no write, `resv_valid`=0. Repeat with snoop at 0x204 → SC succeeds.
- AMOMIN with mem=0xFFFFFFFF, wdata=1 → write 0xFFFFFFFF. AMOMINU with the same values → write 1. With the macro undefined, both → fault, cause 2.
- AMOSWAP at 0x102 → `rsp_fault`=1, cause 1, `rsp_valid` at cycle 1, no memory access. funct5=00101 → cause 2.
- Assert `rst` during WRITE with `mem_ready` held low → next cycle `mem_valid`=0, `cmd_ready`=1, `resv_valid`=0, no `rsp_valid` ever emitted for that command.

Source files
------------

// File: rtl/amo_sequencer.sv
// amo_sequencer: RV32A LR.W/SC.W/AMO*.W read-modify-write sequencer owning the LR/SC reservation.
// Optional macro KIANV_AMO_MINMAX_EN enables AMOMIN/MAX/MINU/MAXU; without it those opcodes fault as illegal.
module amo_sequencer #(
    parameter int RESV_GRANULE_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        resv_valid
);
    localparam int G = RESV_GRANULE_BITS;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND: op_legal = 1'b1;
`ifdef KIANV_AMO_MINMAX_EN
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] amo_alu(input logic [4:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
        case (op)
            OP_ADD:  amo_alu = old + wd;
            OP_XOR:  amo_alu = old ^ wd;
            OP_OR:   amo_alu = old | wd;
            OP_AND:  amo_alu = old & wd;
`ifdef KIANV_AMO_MINMAX_EN
            OP_MIN:  amo_alu = ($signed(old) < $signed(wd)) ? old : wd;
            OP_MAX:  amo_alu = ($signed(old) < $signed(wd)) ? wd : old;
            OP_MINU: amo_alu = (old < wd) ? old : wd;
            OP_MAXU: amo_alu = (old < wd) ? wd : old;
`endif
            default: amo_alu = wd;
        endcase
    endfunction

    state_t        state_r, state_next_s;
    logic [4:0]    op_r;
    logic [31:0]   wdata_r, old_r;
    logic          resv_valid_r;
    logic [31:G]   resv_addr_r;
    logic          mem_valid_r, rsp_valid_r, rsp_fault_r;
    logic [31:0]   mem_addr_r, mem_wdata_r, rsp_rdata_r;
    logic [3:0]    mem_wstrb_r;
    logic [1:0]    rsp_cause_r;

    logic          accept_s, misaligned_s, illegal_s, mem_done_s;
    logic          snoop_hit_resv_s, snoop_hit_req_s, sc_ok_s;
    logic [31:0]   new_data_s;
    logic          unused_s;

    assign accept_s         = (state_r == IDLE) && cmd_valid;
    assign misaligned_s     = (cmd_addr[1:0] != 2'b00);
    assign illegal_s        = !op_legal(cmd_op);
    assign mem_done_s       = mem_valid_r && mem_ready;
    assign snoop_hit_resv_s = snoop_valid && resv_valid_r && (snoop_addr[31:G] == resv_addr_r);
    assign snoop_hit_req_s  = snoop_valid && (snoop_addr[31:G] == mem_addr_r[31:G]);
    // A snoop landing in the SC acceptance cycle kills the reservation first.
    assign sc_ok_s          = resv_valid_r && (cmd_addr[31:G] == resv_addr_r) && !snoop_hit_resv_s;
    assign new_data_s       = amo_alu(op_r, old_r, wdata_r);
    assign unused_s         = ^snoop_addr;

    assign cmd_ready  = (state_r == IDLE);
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_fault  = rsp_fault_r;
    assign rsp_cause  = rsp_cause_r;
    assign mem_valid  = mem_valid_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign resv_valid = resv_valid_r;

    // Next-state selection for the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (misaligned_s || illegal_s) begin
                    state_next_s = RESP;
                end else if (cmd_op != OP_SC) begin
                    state_next_s = READ;
                end else if (sc_ok_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RESP;
                end
            end
            READ: begin
                if (!mem_done_s) begin
                    state_next_s = READ;
                end else if (op_r == OP_LR) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WRITE;
                end
            end
            WRITE: begin
                if (mem_done_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WRITE;
                end
            end
            RESP: begin
                if (rsp_valid_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch, memory request, response and reservation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r         <= 5'd0;
            wdata_r      <= 32'd0;
            old_r        <= 32'd0;
            resv_valid_r <= 1'b0;
            resv_addr_r  <= '0;
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            mem_wstrb_r  <= 4'b0000;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'd0;
            rsp_fault_r  <= 1'b0;
            rsp_cause_r  <= CAUSE_NONE;
        end else begin
            if (snoop_hit_resv_s) begin
                resv_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r        <= cmd_op;
                        wdata_r     <= cmd_wdata;
                        rsp_rdata_r <= 32'd0;
                        rsp_fault_r <= 1'b0;
                        rsp_cause_r <= CAUSE_NONE;
                        if (cmd_op == OP_SC) begin
                            resv_valid_r <= 1'b0;
                        end
                        if (misaligned_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_fault_r <= 1'b1;
                            rsp_cause_r <= CAUSE_MISALIGN;
                        end else if (illegal_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_fault_r <= 1'b1;
                            rsp_cause_r <= CAUSE_ILLEGAL;
                        end else if (cmd_op == OP_SC) begin
                            if (sc_ok_s) begin
                                mem_valid_r <= 1'b1;
                                mem_addr_r  <= {cmd_addr[31:2], 2'b00};
                                mem_wdata_r <= cmd_wdata;
                                mem_wstrb_r <= 4'b1111;
                            end else begin
                                rsp_valid_r <= 1'b1;
                                rsp_rdata_r <= 32'd1;
                            end
                        end else begin
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= {cmd_addr[31:2], 2'b00};
                            mem_wstrb_r <= 4'b0000;
                        end
                    end
                end
                READ: begin
                    if (mem_done_s) begin
                        mem_valid_r <= 1'b0;
                        old_r       <= mem_rdata;
                        rsp_rdata_r <= mem_rdata;
                        if (op_r == OP_LR) begin
                            resv_addr_r  <= mem_addr_r[31:G];
                            resv_valid_r <= !snoop_hit_req_s;
                        end
                    end
                end
                WRITE: begin
                    // AMOs enter with the bus idle for one cycle; SC enters with the write already posted.
                    if (mem_done_s) begin
                        mem_valid_r <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        if (op_r == OP_SC) begin
                            rsp_rdata_r <= 32'd0;
                        end
                    end else if (!mem_valid_r) begin
                        mem_valid_r <= 1'b1;
                        mem_wdata_r <= new_data_s;
                        mem_wstrb_r <= 4'b1111;
                    end
                end
                RESP: begin
                    if (rsp_valid_r) begin
                        rsp_valid_r <= 1'b0;
                        rsp_fault_r <= 1'b0;
                        rsp_cause_r <= CAUSE_NONE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    mem_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed self-checking bench for amo_sequencer with a zero-wait word memory and snoop injector.
module tb_amo_sequencer;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_BAD  = 5'b00101;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_cause;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = 32'd0;
    logic        resv_valid;

    logic [31:0] mem [0:255];
    logic        wr_ready_en;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    int          cyc = 0;
    int          snoop_cyc = -1;
    logic [31:0] snoop_a = 32'd0;
    int          mem_cycles = 0;
    int          rsp_count = 0;
    int          rd_start = -1;
    int          wr_start = -1;
    logic        prev_mv = 1'b0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_wstrb = 4'd0;

    int          checks_n = 0;
    int          errors_n = 0;

    amo_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .resv_valid(resv_valid)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_valid && ((mem_wstrb == 4'h0) || wr_ready_en);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_valid && mem_ready && (mem_wstrb == 4'hF)) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        #1;
        snoop_valid <= (cyc == snoop_cyc);
        snoop_addr  <= snoop_a;
    end

    always @(negedge clk) begin
        if (mem_valid) begin
            mem_cycles <= mem_cycles + 1;
            if (mem_wstrb != 4'h0) begin
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
                last_wstrb <= mem_wstrb;
                if (!prev_mv) wr_start <= cyc;
            end else if (!prev_mv) begin
                rd_start <= cyc;
            end
        end
        prev_mv <= mem_valid;
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        pre_idx = addr[9:2];
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_snoop(input logic [31:0] addr);
        snoop_a   = addr;
        snoop_cyc = cyc + 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command, optionally with a snoop snoop_off cycles after acceptance, and wait for rsp_valid.
    task automatic do_cmd(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int snoop_off, input logic [31:0] s_addr,
                          output logic [31:0] rdata, output logic fault, output logic [1:0] cause,
                          output int lat, output int mem_n, output logic rdy_in_rsp);
        int   c0;
        int   mc0;
        logic got;
        if (snoop_off >= 0) begin
            snoop_a   = s_addr;
            snoop_cyc = cyc + 1 + snoop_off;
        end
        mc0 = mem_cycles;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
        c0 = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 1'b0; lat = -1; rdata = 32'd0; fault = 1'b0; cause = 2'd0; rdy_in_rsp = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = cyc - c0;
                rdata = rsp_rdata; fault = rsp_fault; cause = rsp_cause; rdy_in_rsp = cmd_ready;
            end
        end
        if (!got) check_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        mem_n = mem_cycles - mc0;
    endtask

    logic [31:0] rd;
    logic        flt, rdy;
    logic [1:0]  cs;
    int          lat, mn, rsp_base, base_cyc;
    logic        seen;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 5'd0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        wr_ready_en = 1'b1; pre_en = 1'b0; pre_idx = 8'd0; pre_val = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_resv_valid", {31'd0, resv_valid}, 32'd0);
        check_eq("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);

        // AMOADD wrap to 0x80000000 with full latency profile
        preload(32'h100, 32'h7FFF_FFFF);
        do_cmd(OP_ADD, 32'h100, 32'd1, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("add_rdata", rd, 32'h7FFF_FFFF);
        check_eq("add_fault", {31'd0, flt}, 32'd0);
        check_eq("add_lat", lat, 32'd5);
        check_eq("add_rd_cycle", rd_start - (cyc - lat), 32'd1);
        check_eq("add_wr_cycle", wr_start - (cyc - lat), 32'd3);
        check_eq("add_waddr", last_waddr, 32'h100);
        check_eq("add_wdata", last_wdata, 32'h8000_0000);
        check_eq("add_ready_in_rsp", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        check_eq("add_ready_after", {31'd0, cmd_ready}, 32'd1);
        check_eq("add_mem", mem[64], 32'h8000_0000);

        // LR then SC succeeds, second SC fails without memory access
        preload(32'h200, 32'h0000_1234);
        do_cmd(OP_LR, 32'h200, 32'd0, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("lr_rdata", rd, 32'h1234);
        check_eq("lr_lat", lat, 32'd3);
        check_eq("lr_resv", {31'd0, resv_valid}, 32'd1);
        do_cmd(OP_SC, 32'h200, 32'hCAFE, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("sc_ok_rdata", rd, 32'd0);
        check_eq("sc_ok_lat", lat, 32'd3);
        check_eq("sc_ok_wdata", last_wdata, 32'hCAFE);
        check_eq("sc_ok_wstrb", {28'd0, last_wstrb}, 32'hF);
        check_eq("sc_ok_mem", mem[128], 32'hCAFE);
        check_eq("sc_ok_resv", {31'd0, resv_valid}, 32'd0);
        do_cmd(OP_SC, 32'h200, 32'hBEEF, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("sc2_rdata", rd, 32'd1);
        check_eq("sc2_lat", lat, 32'd1);
        check_eq("sc2_mem_n", mn, 32'd0);

        // Snoop inside the reservation granule kills it; the neighbouring word does not
        do_cmd(OP_LR, 32'h200, 32'd0, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        do_snoop(32'h202);
        check_eq("snp_same_resv", {31'd0, resv_valid}, 32'd0);
        do_cmd(OP_SC, 32'h200, 32'h1111, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("snp_same_sc", rd, 32'd1);
        check_eq("snp_same_mem_n", mn, 32'd0);
        do_cmd(OP_LR, 32'h200, 32'd0, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        do_snoop(32'h204);
        check_eq("snp_next_resv", {31'd0, resv_valid}, 32'd1);
        do_cmd(OP_SC, 32'h200, 32'h2222, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("snp_next_sc", rd, 32'd0);
        check_eq("snp_next_mem", mem[128], 32'h2222);

        // Snoop coincident with SC acceptance and with LR completion
        do_cmd(OP_LR, 32'h200, 32'd0, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        do_cmd(OP_SC, 32'h200, 32'h3333, 0, 32'h200, rd, flt, cs, lat, mn, rdy);
        check_eq("sc_race_rdata", rd, 32'd1);
        check_eq("sc_race_mem_n", mn, 32'd0);
        do_cmd(OP_LR, 32'h204, 32'd0, 1, 32'h204, rd, flt, cs, lat, mn, rdy);
        check_eq("lr_race_resv", {31'd0, resv_valid}, 32'd0);

        // Signed vs unsigned min on 0xFFFFFFFF / 1
        preload(32'h100, 32'hFFFF_FFFF);
        do_cmd(OP_MIN, 32'h100, 32'd1, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
`ifdef KIANV_AMO_MINMAX_EN
        check_eq("min_rdata", rd, 32'hFFFF_FFFF);
        check_eq("min_mem", mem[64], 32'hFFFF_FFFF);
`else
        check_eq("min_cause", {30'd0, cs}, 32'd2);
        check_eq("min_mem_n", mn, 32'd0);
`endif
        preload(32'h100, 32'hFFFF_FFFF);
        do_cmd(OP_MINU, 32'h100, 32'd1, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
`ifdef KIANV_AMO_MINMAX_EN
        check_eq("minu_rdata", rd, 32'hFFFF_FFFF);
        check_eq("minu_mem", mem[64], 32'd1);
`else
        check_eq("minu_fault", {31'd0, flt}, 32'd1);
        check_eq("minu_cause", {30'd0, cs}, 32'd2);
`endif

        // AND and aligned SWAP
        preload(32'h100, 32'h0000_F0F0);
        do_cmd(OP_AND, 32'h100, 32'h0000_FF00, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("and_rdata", rd, 32'h0000_F0F0);
        check_eq("and_mem", mem[64], 32'h0000_F000);
        do_cmd(OP_SWAP, 32'h100, 32'h1234_5678, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("swap_rdata", rd, 32'h0000_F000);
        check_eq("swap_mem", mem[64], 32'h1234_5678);

        // Faults: misaligned, illegal, and misaligned precedence
        do_cmd(OP_SWAP, 32'h102, 32'h9, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("mis_fault", {31'd0, flt}, 32'd1);
        check_eq("mis_cause", {30'd0, cs}, 32'd1);
        check_eq("mis_lat", lat, 32'd1);
        check_eq("mis_mem_n", mn, 32'd0);
        do_cmd(OP_BAD, 32'h100, 32'h9, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("ill_cause", {30'd0, cs}, 32'd2);
        check_eq("ill_mem_n", mn, 32'd0);
        do_cmd(OP_BAD, 32'h101, 32'h9, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        check_eq("mis_ill_cause", {30'd0, cs}, 32'd1);

        // Reset while a write is stalled
        do_cmd(OP_LR, 32'h200, 32'd0, -1, 32'd0, rd, flt, cs, lat, mn, rdy);
        wr_ready_en = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_addr = 32'h100; cmd_wdata = 32'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_valid && (mem_wstrb == 4'hF)) seen = 1'b1;
        end
        check_eq("rst_mid_write_seen", {28'd0, mem_wstrb}, 32'hF);
        rsp_base = rsp_count;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_mid_resv", {31'd0, resv_valid}, 32'd0);
        wr_ready_en = 1'b1;
        base_cyc = cyc;
        repeat (10) @(negedge clk);
        check_eq("rst_mid_no_rsp", rsp_count - rsp_base, 32'd0);
        check_eq("rst_mid_mem_kept", mem[64], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end
endmodule
